aes_gcm_instance_scheduler: RTL and testbench
=============================================

# aes_gcm_instance_scheduler

Sequences AES-GCM instances into the encryption pipeline front end. Accepts one command per instance (IV, AAD/PT block counts, length block) and then a stream of 128-bit data blocks. Emits exactly one registered beat per block into the stage that derives H and J0, with `o_new_instance` and `o_pt_instance` framing the instance. The pipeline cannot stall, so this block owns all flow control and inserts the inter-instance gap that the GHASH tail requires.

## Interface
- `CNT_W`, 16: width of the AAD and PT block counts.
- `MIN_GAP`, 2: idle cycles (`o_valid`=0) forced between the last beat of one instance and the first beat of the next; legal range 0..15.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_iv`  in  [0:95]  instance IV.
- `cmd_aad_blocks`, `cmd_pt_blocks`  in  CNT_W  block counts.
- `cmd_size`  in  [0:127]  len(A)||len(C) block, forwarded unchanged.
- `in_valid` / `in_ready`  in/out  1  data handshake.
- `in_data`  in  [0:127]  AAD blocks first, then PT blocks.
- `o_valid`  out  1  beat valid.
- `o_iv`  out  [0:95]  IV of the current instance.
- `o_plain_text`, `o_aad`  out  [0:127]  beat payload; the unused lane is 0.
- `o_instance_size`  out  [0:127]  `cmd_size` of the current instance.
- `o_new_instance`  out  1  first beat of the instance.
- `o_pt_instance`  out  1  beat is plaintext.
- `o_busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, AAD, PT, GAP.
- **IDLE:** `cmd_ready`=1. A command handshake latches IV, counts and size, and sets the `first` flag.
  - aad>0: go to AAD.
  - aad=0, pt>0: go to PT.
  - both 0: emit one empty beat (payloads 0, `o_new_instance`=1, `o_pt_instance`=0) so H/J0 are still produced, then go to GAP.
- **AAD / PT:** `in_ready`=1; `cmd_ready`=0.
  - Each data handshake emits one beat: data on `o_aad` (AAD) or `o_plain_text` (PT), `o_pt_instance`=(state==PT), `o_new_instance`=`first`. `first` then clears.
  - The remaining-count register decrements on each handshake. At 0 the FSM moves AAD→PT (if pt>0) or →GAP.
- **GAP:** a counter loads MIN_GAP−1 and decrements to 0, then the FSM returns to IDLE. With MIN_GAP=0, GAP is skipped and the FSM goes straight to IDLE.
- `o_iv` and `o_instance_size` hold the latched values from command accept until the next command is accepted.
- Counts are unsigned. A count of 2^CNT_W−1 is legal. There is no wrap: the counter stops at 0.
- When `o_valid`=0, `o_new_instance`, `o_pt_instance` and both payloads are 0.
- The `in_data` stream is not checked for excess blocks; extra blocks stay unaccepted because `in_ready`=0.

## Timing
- A handshake in cycle t produces the beat (`o_valid`=1) at t+1. Throughput is one block per cycle with no bubbles inside an instance.
- A command accepted at t makes `in_ready`=1 at t+1, so the first beat appears at t+2 at the earliest. The empty-instance beat appears at t+1.
- Last beat at t+1 → `cmd_ready`=1 at t+2+MIN_GAP.
- `cmd_ready` and `in_ready` are decoded from registered state only, with no combinational path from `*_valid`.
- **Reset:** state IDLE. All outputs are 0 except `cmd_ready`, which is 0 during reset and 1 in the first cycle after deassertion. Reset mid-instance discards the instance with no partial-beat flush; any beat registered in that cycle is cleared.

## Configuration
- `AES_GCM_SCHED_PERF_EN` defined: adds outputs `o_inst_count` [31:0] and `o_starve_count` [31:0].
  - `o_inst_count` increments on each command accept.
  - `o_starve_count` increments each AAD/PT cycle with `in_valid`=0.
  - Both counters wrap and clear on reset.
- Macro undefined: these ports and counters do not exist.

## Structure
- Shared package `aes_gcm_pkg`: state enum `sched_state_t`, a beat struct (iv, aad, pt, size, flags), and `BLOCK_W`=128 and `IV_W`=96.
- One sub-module, `aes_gcm_gap_timer` (load/decrement/done), used for GAP; all other logic is inline.

## Test plan
- **AAD then PT:** aad=2, pt=3, 5 back-to-back blocks D0..D4 → 5 consecutive beats. `o_new_instance` is 1 only on D0. `o_pt_instance` = 0,0,1,1,1. `o_aad` = D0,D1, then `o_plain_text` = D2..D4.
- **Empty instance:** aad=0, pt=0, IV=0xCAFEBABE… → single beat at t+1 with payloads 0 and `o_new_instance`=1; `cmd_ready` returns at t+2+MIN_GAP.
- **Starvation:** aad=0, pt=4, `in_valid` toggling 1,0,1,0… → 4 beats, each one cycle after its handshake; `o_busy` stays 1 throughout. With the macro defined, `o_starve_count` = 3.
- **Back-to-back commands with MIN_GAP=2:** exactly 2 invalid cycles between the last beat of instance A and `cmd_ready`; `o_iv` switches from A's to B's IV on B's accept.
- **Reset mid-instance:** pt=8, reset asserted after 3 beats → next cycle `o_valid`=0, state IDLE; a new command with pt=1 yields one beat with `o_new_instance`=1.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared types and widths for the AES-GCM front-end scheduler: FSM state
// encoding and the registered beat handed to the H/J0 stage.
package aes_gcm_pkg;

    localparam int BLOCK_W = 128;
    localparam int IV_W    = 96;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AAD  = 2'd1,
        ST_PT   = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [0:IV_W-1]    iv;
        logic [0:BLOCK_W-1] aad;
        logic [0:BLOCK_W-1] pt;
        logic [0:BLOCK_W-1] size;
        logic               new_inst;
        logic               pt_inst;
        logic               valid;
    } beat_t;

endpackage

// File: rtl/aes_gcm_gap_timer.sv
// Down-counter that times the idle tail between instances; loads, counts to 0
// and holds there, flagging done while at 0.
module aes_gcm_gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Count register: load has priority, otherwise saturating decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/aes_gcm_instance_scheduler.sv
// Sequences AES-GCM instances (command + AAD/PT blocks) into the pipeline front end.
// Optional perf counters are built when AES_GCM_SCHED_PERF_EN is defined.
module aes_gcm_instance_scheduler
    import aes_gcm_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int MIN_GAP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [0:IV_W-1]    cmd_iv,
    input  logic [CNT_W-1:0]   cmd_aad_blocks,
    input  logic [CNT_W-1:0]   cmd_pt_blocks,
    input  logic [0:BLOCK_W-1] cmd_size,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:BLOCK_W-1] in_data,
    output logic               o_valid,
    output logic [0:IV_W-1]    o_iv,
    output logic [0:BLOCK_W-1] o_plain_text,
    output logic [0:BLOCK_W-1] o_aad,
    output logic [0:BLOCK_W-1] o_instance_size,
    output logic               o_new_instance,
    output logic               o_pt_instance,
    output logic               o_busy
`ifdef AES_GCM_SCHED_PERF_EN
    ,
    output logic [31:0]        o_inst_count,
    output logic [31:0]        o_starve_count
`endif
);

    localparam logic [3:0]   GAP_LOAD = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);
    localparam sched_state_t ST_AFTER = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;

    sched_state_t     r_state;
    sched_state_t     w_next_state;
    beat_t            r_beat;
    beat_t            w_beat;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_pt_cnt;
    logic             r_first;
    logic             w_cmd_hs;
    logic             w_in_hs;
    logic             w_last_blk;
    logic             w_cmd_empty;
    logic             w_gap_load;
    logic             w_gap_done;

    // Ready is a pure state decode; rst_n only masks it while reset is held.
    assign cmd_ready   = rst_n && (r_state == ST_IDLE);
    assign in_ready    = (r_state == ST_AAD) || (r_state == ST_PT);
    assign w_cmd_hs    = cmd_ready && cmd_valid;
    assign w_in_hs     = in_ready && in_valid;
    assign w_last_blk  = (r_remain == CNT_W'(1));
    assign w_cmd_empty = (cmd_aad_blocks == '0) && (cmd_pt_blocks == '0);
    // The beat cycle is the first GAP cycle, so the idle count starts after it.
    assign w_gap_load  = (r_state == ST_GAP) && r_beat.valid;

    aes_gcm_gap_timer #(
        .W          (4)
    ) u_gap_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_gap_load),
        .i_load_val (GAP_LOAD),
        .o_done     (w_gap_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_cmd_hs) begin
                    w_next_state = ST_IDLE;
                end else if (cmd_aad_blocks != '0) begin
                    w_next_state = ST_AAD;
                end else if (cmd_pt_blocks != '0) begin
                    w_next_state = ST_PT;
                end else begin
                    w_next_state = ST_AFTER;
                end
            end
            ST_AAD: begin
                if (w_in_hs && w_last_blk) begin
                    w_next_state = (r_pt_cnt != '0) ? ST_PT : ST_AFTER;
                end else begin
                    w_next_state = ST_AAD;
                end
            end
            ST_PT: begin
                if (w_in_hs && w_last_blk) begin
                    w_next_state = ST_AFTER;
                end else begin
                    w_next_state = ST_PT;
                end
            end
            ST_GAP: begin
                if (!w_gap_load && w_gap_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Beat composition; payloads and flags default to 0, IV/size hold.
    always_comb begin
        w_beat      = '0;
        w_beat.iv   = r_beat.iv;
        w_beat.size = r_beat.size;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    w_beat.iv       = cmd_iv;
                    w_beat.size     = cmd_size;
                    w_beat.valid    = w_cmd_empty;
                    w_beat.new_inst = w_cmd_empty;
                end else begin
                    w_beat.valid = 1'b0;
                end
            end
            ST_AAD: begin
                if (w_in_hs) begin
                    w_beat.valid    = 1'b1;
                    w_beat.aad      = in_data;
                    w_beat.new_inst = r_first;
                end else begin
                    w_beat.valid = 1'b0;
                end
            end
            ST_PT: begin
                if (w_in_hs) begin
                    w_beat.valid    = 1'b1;
                    w_beat.pt       = in_data;
                    w_beat.pt_inst  = 1'b1;
                    w_beat.new_inst = r_first;
                end else begin
                    w_beat.valid = 1'b0;
                end
            end
            ST_GAP:  w_beat.valid = 1'b0;
            default: w_beat.valid = 1'b0;
        endcase
    end

    // Beat register; reset drops any beat formed in the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else begin
            r_beat <= w_beat;
        end
    end

    // Block counters and first-beat flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_remain <= '0;
            r_pt_cnt <= '0;
            r_first  <= 1'b0;
        end else if (w_cmd_hs) begin
            r_remain <= (cmd_aad_blocks != '0) ? cmd_aad_blocks : cmd_pt_blocks;
            r_pt_cnt <= cmd_pt_blocks;
            r_first  <= 1'b1;
        end else if (w_in_hs) begin
            r_first <= 1'b0;
            if ((r_state == ST_AAD) && w_last_blk) begin
                r_remain <= r_pt_cnt;
            end else if (r_remain != '0) begin
                r_remain <= r_remain - CNT_W'(1);
            end else begin
                r_remain <= r_remain;
            end
        end else begin
            r_remain <= r_remain;
            r_first  <= r_first;
        end
    end

    assign o_valid         = r_beat.valid;
    assign o_iv            = r_beat.iv;
    assign o_aad           = r_beat.aad;
    assign o_plain_text    = r_beat.pt;
    assign o_instance_size = r_beat.size;
    assign o_new_instance  = r_beat.new_inst;
    assign o_pt_instance   = r_beat.pt_inst;
    assign o_busy          = (r_state != ST_IDLE);

`ifdef AES_GCM_SCHED_PERF_EN
    logic [31:0] r_inst_count;
    logic [31:0] r_starve_count;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst_count   <= 32'd0;
            r_starve_count <= 32'd0;
        end else begin
            r_inst_count   <= w_cmd_hs ? (r_inst_count + 32'd1) : r_inst_count;
            r_starve_count <= (in_ready && !in_valid) ? (r_starve_count + 32'd1)
                                                      : r_starve_count;
        end
    end

    assign o_inst_count   = r_inst_count;
    assign o_starve_count = r_starve_count;
`endif

endmodule

// File: tb/tb_aes_gcm_instance_scheduler.sv
// Directed self-checking bench for aes_gcm_instance_scheduler (MIN_GAP=2).
module tb_aes_gcm_instance_scheduler;

    localparam int CNT_W   = 16;
    localparam int MIN_GAP = 2;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [0:95]        cmd_iv;
    logic [CNT_W-1:0]   cmd_aad_blocks;
    logic [CNT_W-1:0]   cmd_pt_blocks;
    logic [0:127]       cmd_size;
    logic               in_valid;
    logic               in_ready;
    logic [0:127]       in_data;
    logic               o_valid;
    logic [0:95]        o_iv;
    logic [0:127]       o_plain_text;
    logic [0:127]       o_aad;
    logic [0:127]       o_instance_size;
    logic               o_new_instance;
    logic               o_pt_instance;
    logic               o_busy;
`ifdef AES_GCM_SCHED_PERF_EN
    logic [31:0]        o_inst_count;
    logic [31:0]        o_starve_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    aes_gcm_instance_scheduler #(
        .CNT_W           (CNT_W),
        .MIN_GAP         (MIN_GAP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_iv          (cmd_iv),
        .cmd_aad_blocks  (cmd_aad_blocks),
        .cmd_pt_blocks   (cmd_pt_blocks),
        .cmd_size        (cmd_size),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .o_valid         (o_valid),
        .o_iv            (o_iv),
        .o_plain_text    (o_plain_text),
        .o_aad           (o_aad),
        .o_instance_size (o_instance_size),
        .o_new_instance  (o_new_instance),
        .o_pt_instance   (o_pt_instance),
        .o_busy          (o_busy)
`ifdef AES_GCM_SCHED_PERF_EN
        ,
        .o_inst_count    (o_inst_count),
        .o_starve_count  (o_starve_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:127] data;
        logic         exp_new;
        logic         exp_pt;
        logic [0:127] exp_aad;
        logic [0:127] exp_ptxt;
    } vec_t;

    vec_t tab [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called in the cycle holding an instance's last beat.
    task automatic check_gap(input string tag);
        for (int g = 1; g <= MIN_GAP; g++) begin
            tick();
            chk1({tag, "_gap_valid"}, o_valid, 1'b0);
            chk1({tag, "_gap_cmd_ready"}, cmd_ready, 1'b0);
            chk1({tag, "_gap_busy"}, o_busy, 1'b1);
        end
        tick();
        chk1({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
        chk1({tag, "_idle_busy"}, o_busy, 1'b0);
    endtask

    // Drives a command for one cycle; returns in the cycle after acceptance.
    task automatic send_cmd(input logic [0:95] iv, input logic [CNT_W-1:0] aad,
                            input logic [CNT_W-1:0] pt, input logic [0:127] sz);
        cmd_valid      = 1'b1;
        cmd_iv         = iv;
        cmd_aad_blocks = aad;
        cmd_pt_blocks  = pt;
        cmd_size       = sz;
        tick();
        cmd_valid      = 1'b0;
    endtask

    logic [0:95]  iv_a;
    logic [0:95]  iv_b;
    logic [0:127] sz_a;
    logic [0:127] blk;
    logic         pat [7];

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_iv         = '0;
        cmd_aad_blocks = '0;
        cmd_pt_blocks  = '0;
        cmd_size       = '0;
        in_valid       = 1'b0;
        in_data        = '0;

        for (int i = 0; i < 5; i++) begin
            tab[i].data     = {32'hD0D0_0000 + 32'(i), 96'h0123_4567_89AB_CDEF_FEDC_BA98};
            tab[i].exp_new  = (i == 0);
            tab[i].exp_pt   = (i >= 2);
            tab[i].exp_aad  = (i < 2)  ? tab[i].data : 128'h0;
            tab[i].exp_ptxt = (i >= 2) ? tab[i].data : 128'h0;
        end

        // Reset state
        tick();
        tick();
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_valid", o_valid, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk128("rst_iv", {32'h0, o_iv}, 128'h0);
        chk128("rst_size", o_instance_size, 128'h0);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

        // AAD then PT: aad=2, pt=3
        iv_a = 96'h1111_2222_3333_4444_5555_6666;
        sz_a = 128'h0000_0000_0000_0100_0000_0000_0000_0180;
        send_cmd(iv_a, 16'd2, 16'd3, sz_a);
        chk1("t1_in_ready", in_ready, 1'b1);
        chk1("t1_cmd_ready", cmd_ready, 1'b0);
        chk1("t1_pre_valid", o_valid, 1'b0);
        chk128("t1_iv", {32'h0, o_iv}, {32'h0, iv_a});
        chk128("t1_size", o_instance_size, sz_a);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = tab[i].data;
            tick();
            chk1($sformatf("t1_valid_%0d", i), o_valid, 1'b1);
            chk1($sformatf("t1_new_%0d", i), o_new_instance, tab[i].exp_new);
            chk1($sformatf("t1_ptinst_%0d", i), o_pt_instance, tab[i].exp_pt);
            chk128($sformatf("t1_aad_%0d", i), o_aad, tab[i].exp_aad);
            chk128($sformatf("t1_pt_%0d", i), o_plain_text, tab[i].exp_ptxt);
        end
        in_valid = 1'b0;
        chk1("t1_in_ready_off", in_ready, 1'b0);
        check_gap("t1");

        // Empty instance
        iv_b = 96'hCAFE_BABE_DEAD_BEEF_0BAD_F00D;
        send_cmd(iv_b, 16'd0, 16'd0, 128'h0);
        chk1("t2_valid", o_valid, 1'b1);
        chk1("t2_new", o_new_instance, 1'b1);
        chk1("t2_ptinst", o_pt_instance, 1'b0);
        chk128("t2_aad", o_aad, 128'h0);
        chk128("t2_pt", o_plain_text, 128'h0);
        chk128("t2_iv", {32'h0, o_iv}, {32'h0, iv_b});
        chk1("t2_in_ready", in_ready, 1'b0);
        check_gap("t2");

        // Starvation: pt=4, in_valid 1,0,1,0,1,0,1
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        send_cmd(iv_a, 16'd0, 16'd4, sz_a);
        for (int k = 0; k < 7; k++) begin
            blk      = {96'h0, 32'h5000_0000 + 32'(k)};
            in_valid = pat[k];
            in_data  = blk;
            tick();
            chk1($sformatf("t3_valid_%0d", k), o_valid, pat[k]);
            chk1($sformatf("t3_busy_%0d", k), o_busy, 1'b1);
            chk128($sformatf("t3_pt_%0d", k), o_plain_text, pat[k] ? blk : 128'h0);
            chk1($sformatf("t3_new_%0d", k), o_new_instance, pat[k] && (k == 0));
            chk1($sformatf("t3_ptinst_%0d", k), o_pt_instance, pat[k]);
        end
        in_valid = 1'b0;
`ifdef AES_GCM_SCHED_PERF_EN
        chk128("t3_starve", {96'h0, o_starve_count}, 128'd3);
        chk128("t3_inst", {96'h0, o_inst_count}, 128'd3);
`endif
        check_gap("t3");

        // Back-to-back commands: B waits on cmd_valid through A's gap
        send_cmd(iv_a, 16'd1, 16'd1, sz_a);
        in_valid = 1'b1;
        in_data  = tab[0].data;
        tick();
        in_data  = tab[2].data;
        tick();
        in_valid = 1'b0;
        chk1("t4_last_valid", o_valid, 1'b1);
        chk1("t4_last_ptinst", o_pt_instance, 1'b1);
        cmd_valid      = 1'b1;
        cmd_iv         = iv_b;
        cmd_aad_blocks = 16'd0;
        cmd_pt_blocks  = 16'd1;
        cmd_size       = 128'h77;
        for (int g = 1; g <= MIN_GAP; g++) begin
            tick();
            chk1($sformatf("t4_gap_valid_%0d", g), o_valid, 1'b0);
            chk1($sformatf("t4_gap_ready_%0d", g), cmd_ready, 1'b0);
            chk128($sformatf("t4_gap_iv_%0d", g), {32'h0, o_iv}, {32'h0, iv_a});
        end
        tick();
        chk1("t4_ready_back", cmd_ready, 1'b1);
        chk128("t4_iv_before_accept", {32'h0, o_iv}, {32'h0, iv_a});
        tick();
        cmd_valid = 1'b0;
        chk128("t4_iv_after_accept", {32'h0, o_iv}, {32'h0, iv_b});
        chk128("t4_size_after_accept", o_instance_size, 128'h77);
        chk1("t4_b_cmd_ready", cmd_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = tab[4].data;
        tick();
        in_valid = 1'b0;
        chk1("t4_b_valid", o_valid, 1'b1);
        chk1("t4_b_new", o_new_instance, 1'b1);
        chk128("t4_b_pt", o_plain_text, tab[4].data);
        check_gap("t4");

        // Reset mid-instance: pt=8, reset after 3 beats
        send_cmd(iv_a, 16'd0, 16'd8, sz_a);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = tab[k].data;
            tick();
            chk1($sformatf("t5_valid_%0d", k), o_valid, 1'b1);
        end
        in_data = tab[3].data;
        rst_n   = 1'b0;
        tick();
        chk1("t5_rst_valid", o_valid, 1'b0);
        chk1("t5_rst_busy", o_busy, 1'b0);
        chk1("t5_rst_in_ready", in_ready, 1'b0);
        chk1("t5_rst_cmd_ready", cmd_ready, 1'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk1("t5_cmd_ready", cmd_ready, 1'b1);
        send_cmd(iv_b, 16'd0, 16'd1, 128'h0);
        in_valid = 1'b1;
        in_data  = tab[1].data;
        tick();
        in_valid = 1'b0;
        chk1("t5_new_valid", o_valid, 1'b1);
        chk1("t5_new_new", o_new_instance, 1'b1);
        chk128("t5_new_pt", o_plain_text, tab[1].data);
`ifdef AES_GCM_SCHED_PERF_EN
        chk128("t5_inst", {96'h0, o_inst_count}, 128'd1);
        chk128("t5_starve", {96'h0, o_starve_count}, 128'd0);
`endif
        check_gap("t5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
